snoopy_bus_arbiter: RTL and testbench
=====================================

Name: snoopy_bus_arbiter

Overview:
- Shares the single snoopy coherence bus among NUM_CACHES cache controllers.
- Grants the bus round-robin, then broadcasts the winner's bus command to all snoopers.
- Collects the snoopers' supply/write-back indications and sequences either a cache-to-cache transfer (with optional RAM write-back) or a RAM read, then retires the transaction.

Parameters:
- NUM_CACHES, 4, number of requesting caches (2..16)
- INDEX_WIDTH, $clog2(NUM_CACHES), width of cache index fields

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- busRequest  in  NUM_CACHES  per-cache bus request; held until busDone
- busCommandIn  in  2*NUM_CACHES  per-cache command, slice i = cache i: 0 NONE, 1 BUS_READ, 2 BUS_READ_EXCLUSIVE, 3 BUS_INVALIDATE
- busGrant  out  NUM_CACHES  one-hot grant
- commandOut  out  2  broadcast command; NONE when no transaction
- commandValid  out  1  broadcast qualifier for snoopers
- snoopSupply  in  NUM_CACHES  snooper i holds the line MODIFIED (its protocol request output)
- snoopRamWrite  in  NUM_CACHES  snooper i needs a RAM write (protocol ramWriteRequired)
- sourceIsCache  out  1  data source is a cache (1) or RAM (0)
- sourceIndex  out  INDEX_WIDTH  supplying cache index
- ramRead  out  1  RAM read strobe, held until ramAck
- ramWrite  out  1  RAM write strobe, held until ramAck
- ramAck  in  1  RAM completion, one cycle
- busDone  out  1  one-cycle pulse to the granted cache
- protocolError  out  1  sticky; more than one snoopSupply seen

Behaviour:
- Reset: every output is 0, the state is IDLE, and the round-robin pointer is 0. Reset wins over every other event, including mid-transaction. protocolError clears only on reset.
- IDLE: if any busRequest is set, pick the first requester at or after the pointer (cyclic). busGrant is registered one cycle later. The pointer becomes winner+1 mod NUM_CACHES. The winner's command is latched. Go to BROADCAST.
- BROADCAST, exactly 1 cycle: commandValid=1 and commandOut=latched command. snoopSupply and snoopRamWrite are sampled at the end of this cycle, masked by ~busGrant.
  - BUS_INVALIDATE or NONE -> DONE.
  - Masked supply present -> CACHE_XFER, with sourceIsCache=1 and sourceIndex = lowest set index.
  - No supply -> RAM_READ.
- CACHE_XFER: if the supplier's snoopRamWrite is set, assert ramWrite until ramAck, then go to DONE. Otherwise the transfer lasts 1 cycle, then DONE.
- RAM_READ: assert ramRead until ramAck, then go to DONE. sourceIsCache=0.
- DONE, 1 cycle: busDone=1. Next cycle busGrant, commandValid, sourceIsCache and sourceIndex return to 0 and the state is IDLE.
- Arbitration always leaves one idle cycle after DONE. Back-to-back grants are therefore at least 4 cycles apart.
- busGrant and commandOut are held constant from grant through DONE.
- Withdrawing busRequest mid-transaction has no effect; the transaction completes.
- New requests arriving mid-transaction wait.
- More than one masked snoopSupply: set protocolError and use the lowest index.
- ramAck outside RAM_READ, or outside CACHE_XFER with write-back, is ignored.
- NUM_CACHES=2: the pointer toggles.

Test Plan:
- Single read miss: cache1 requests BUS_READ with no supply. Grant=0010 one cycle later, then BROADCAST, then ramRead. ramAck is given 3 cycles later. busDone pulses once, and ramWrite never asserts.
- Dirty read hit: cache0 requests BUS_READ while snoopSupply=0100 and snoopRamWrite=0100. Expect sourceIsCache=1, sourceIndex=2, then ramWrite until ack, then busDone.
- Invalidate: cache3 requests BUS_INVALIDATE. Expect one BROADCAST cycle with commandOut=3, then DONE. No RAM strobes assert.
- Round-robin: all four request continuously. Grants occur in order 0,1,2,3,0. Requesters 0 and 2 only, pointer at 1: expect grant to 2 first.
- Self-supply and multiple supply: the granter's own snoopSupply is ignored, so the RAM read path is taken. snoopSupply=1010 with cache0 granted gives sourceIndex=1 and protocolError=1 until reset.
- Reset mid-RAM_READ: assert reset while ramRead=1. Next cycle all outputs are 0 and the state is IDLE. A subsequent request from cache2 is granted on pointer 0 → 2.

Source files
------------

// File: rtl/snoopy_bus_arbiter_if.sv
// Coherence bus bundle between the snoopy bus arbiter and its cache controllers / RAM port.
// The arbiter uses the master modport; the caches and RAM side use the slave modport.
interface snoopy_bus_arbiter_if #(
    parameter int NUM_CACHES  = 4,
    parameter int INDEX_WIDTH = $clog2(NUM_CACHES)
);
    logic [NUM_CACHES-1:0]   busRequest;
    logic [2*NUM_CACHES-1:0] busCommandIn;
    logic [NUM_CACHES-1:0]   busGrant;
    logic [1:0]              commandOut;
    logic                    commandValid;
    logic [NUM_CACHES-1:0]   snoopSupply;
    logic [NUM_CACHES-1:0]   snoopRamWrite;
    logic                    sourceIsCache;
    logic [INDEX_WIDTH-1:0]  sourceIndex;
    logic                    ramRead;
    logic                    ramWrite;
    logic                    ramAck;
    logic                    busDone;
    logic                    protocolError;

    modport master (
        input  busRequest, busCommandIn, snoopSupply, snoopRamWrite, ramAck,
        output busGrant, commandOut, commandValid, sourceIsCache, sourceIndex,
        output ramRead, ramWrite, busDone, protocolError
    );

    modport slave (
        output busRequest, busCommandIn, snoopSupply, snoopRamWrite, ramAck,
        input  busGrant, commandOut, commandValid, sourceIsCache, sourceIndex,
        input  ramRead, ramWrite, busDone, protocolError
    );
endinterface

// File: rtl/snoopy_bus_arbiter.sv
// Round-robin owner of the snoopy coherence bus: grants one cache, broadcasts its command,
// then sequences a cache-to-cache transfer (optional RAM write-back) or a RAM read.
module snoopy_bus_arbiter #(
    parameter int NUM_CACHES  = 4,
    parameter int INDEX_WIDTH = $clog2(NUM_CACHES)
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    snoopy_bus_arbiter_if.master bus
);
    // IDLE: arbitrate | BROADCAST: command on bus | CACHE_XFER: cache supplies line
    // RAM_READ: memory supplies line | DONE: busDone pulse, then back to IDLE
    typedef enum logic [2:0] {
        S_IDLE,
        S_BROADCAST,
        S_CACHE_XFER,
        S_RAM_READ,
        S_DONE
    } state_t;

    localparam logic [1:0] CMD_NONE = 2'd0;
    localparam logic [1:0] CMD_INV  = 2'd3;

    state_t                  state_q;
    logic [INDEX_WIDTH-1:0]  ptr_q;
    logic                    idle_hold_q;
    logic [NUM_CACHES-1:0]   grant_q;
    logic [1:0]              cmd_q;
    logic                    cmd_valid_q;
    logic                    src_cache_q;
    logic [INDEX_WIDTH-1:0]  src_idx_q;
    logic                    ram_read_q;
    logic                    ram_write_q;
    logic                    done_q;
    logic                    perr_q;

    logic                    win_found;
    logic [INDEX_WIDTH-1:0]  win_idx;
    logic [NUM_CACHES-1:0]   win_onehot;
    logic [1:0]              win_cmd;
    logic [INDEX_WIDTH-1:0]  ptr_d;

    logic [NUM_CACHES-1:0]   masked_sup;
    logic                    sup_found;
    logic                    sup_multi;
    logic [INDEX_WIDTH-1:0]  sup_idx;
    logic                    sup_wb;

    // Scan downwards so the last hit is the first requester at or after the pointer.
    always_comb begin
        int j;
        logic [INDEX_WIDTH-1:0]  cand;
        logic [2*NUM_CACHES-1:0] cmd_shift;
        j          = 0;
        cand       = '0;
        cmd_shift  = '0;
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        win_cmd    = CMD_NONE;
        for (int i = NUM_CACHES - 1; i >= 0; i--) begin
            j = int'(ptr_q) + i;
            if (j >= NUM_CACHES) begin
                j = j - NUM_CACHES;
            end
            cand = INDEX_WIDTH'(j);
            if (bus.busRequest[cand]) begin
                win_found        = 1'b1;
                win_idx          = cand;
                win_onehot       = '0;
                win_onehot[cand] = 1'b1;
                cmd_shift        = bus.busCommandIn >> (2 * j);
                win_cmd          = cmd_shift[1:0];
            end
        end
        if (int'(win_idx) == NUM_CACHES - 1) begin
            ptr_d = '0;
        end else begin
            ptr_d = win_idx + 1'b1;
        end
    end

    always_comb begin
        masked_sup = bus.snoopSupply & ~grant_q;
        sup_found  = |masked_sup;
        sup_multi  = ($countones(masked_sup) > 1);
        sup_idx    = '0;
        sup_wb     = 1'b0;
        for (int i = NUM_CACHES - 1; i >= 0; i--) begin
            if (masked_sup[i]) begin
                sup_idx = INDEX_WIDTH'(i);
                sup_wb  = bus.snoopRamWrite[i];
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            idle_hold_q <= 1'b0;
            grant_q     <= '0;
            cmd_q       <= CMD_NONE;
            cmd_valid_q <= 1'b0;
            src_cache_q <= 1'b0;
            src_idx_q   <= '0;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
            done_q      <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (idle_hold_q) begin
                        idle_hold_q <= 1'b0;
                    end else if (win_found) begin
                        grant_q     <= win_onehot;
                        cmd_q       <= win_cmd;
                        cmd_valid_q <= 1'b1;
                        ptr_q       <= ptr_d;
                        state_q     <= S_BROADCAST;
                    end
                end
                S_BROADCAST: begin
                    cmd_valid_q <= 1'b0;
                    perr_q      <= perr_q | sup_multi;
                    if (cmd_q == CMD_NONE || cmd_q == CMD_INV) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (sup_found) begin
                        src_cache_q <= 1'b1;
                        src_idx_q   <= sup_idx;
                        ram_write_q <= sup_wb;
                        state_q     <= S_CACHE_XFER;
                    end else begin
                        ram_read_q <= 1'b1;
                        state_q    <= S_RAM_READ;
                    end
                end
                S_CACHE_XFER: begin
                    if (!ram_write_q || bus.ramAck) begin
                        ram_write_q <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_RAM_READ: begin
                    if (bus.ramAck) begin
                        ram_read_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q      <= 1'b0;
                    grant_q     <= '0;
                    cmd_q       <= CMD_NONE;
                    src_cache_q <= 1'b0;
                    src_idx_q   <= '0;
                    idle_hold_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busGrant      = grant_q;
    assign bus.commandOut    = cmd_q;
    assign bus.commandValid  = cmd_valid_q;
    assign bus.sourceIsCache = src_cache_q;
    assign bus.sourceIndex   = src_idx_q;
    assign bus.ramRead       = ram_read_q;
    assign bus.ramWrite      = ram_write_q;
    assign bus.busDone       = done_q;
    assign bus.protocolError = perr_q;
endmodule

// File: tb/tb_snoopy_bus_arbiter.sv
// Directed bench for snoopy_bus_arbiter: expected transactions are queued as requests are
// driven and retired against what the arbiter shows when busDone pulses.
module tb_snoopy_bus_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    snoopy_bus_arbiter_if #(.NUM_CACHES(N), .INDEX_WIDTH(IW)) bus ();

    snoopy_bus_arbiter #(.NUM_CACHES(N), .INDEX_WIDTH(IW)) dut (
        .clock_i (clock),
        .reset_i (reset),
        .bus     (bus)
    );

    typedef struct {
        logic [N-1:0]  grant;
        logic [1:0]    cmd;
        logic          src_cache;
        logic [IW-1:0] src_idx;
        int            rr_cyc;
        int            rw_cyc;
    } exp_t;

    exp_t sb[$];
    int   vectors          = 0;
    int   miscompares      = 0;
    int   cycle            = 0;
    int   last_grant_cycle = -1000;

    always @(posedge clock) cycle <= cycle + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [N-1:0] g, input logic [1:0] c, input logic sc,
                            input logic [IW-1:0] si, input int rr, input int rw);
        exp_t e;
        e.grant     = g;
        e.cmd       = c;
        e.src_cache = sc;
        e.src_idx   = si;
        e.rr_cyc    = rr;
        e.rw_cyc    = rw;
        sb.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, bus.busGrant, 0);
        chk({tag, "_cmd"}, bus.commandOut, 0);
        chk({tag, "_cvalid"}, bus.commandValid, 0);
        chk({tag, "_srccache"}, bus.sourceIsCache, 0);
        chk({tag, "_srcidx"}, bus.sourceIndex, 0);
        chk({tag, "_ramrd"}, bus.ramRead, 0);
        chk({tag, "_ramwr"}, bus.ramWrite, 0);
        chk({tag, "_done"}, bus.busDone, 0);
        chk({tag, "_perr"}, bus.protocolError, 0);
    endtask

    // Waits for a grant, checks the broadcast cycle, acks RAM strobes after ack_delay
    // cycles of strobe, and retires the head of the scoreboard on busDone.
    task automatic run_txn(input int ack_delay, input bit early_drop, input logic [N-1:0] drop_mask);
        exp_t e;
        int   n;
        int   rr_cyc;
        int   rw_cyc;
        bit   done;
        rr_cyc = 0;
        rw_cyc = 0;
        done   = 1'b0;
        n      = 0;
        while (bus.busGrant === '0 && n < 12) begin
            tick();
            n++;
        end
        e = sb[0];
        chk("bcast_grant", bus.busGrant, e.grant);
        chk("bcast_valid", bus.commandValid, 1);
        chk("bcast_cmd", bus.commandOut, e.cmd);
        chk("grant_gap", (cycle - last_grant_cycle) >= 4, 1);
        last_grant_cycle = cycle;
        if (early_drop) bus.busRequest &= ~e.grant;
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
            bus.ramAck = 1'b0;
            if (bus.ramRead === 1'b1) rr_cyc++;
            if (bus.ramWrite === 1'b1) rw_cyc++;
            if ((bus.ramRead === 1'b1 || bus.ramWrite === 1'b1) && (rr_cyc + rw_cyc) == ack_delay)
                bus.ramAck = 1'b1;
            if (bus.busDone === 1'b1) done = 1'b1;
        end
        bus.ramAck = 1'b0;
        chk("done_seen", done, 1);
        e = sb.pop_front();
        chk("done_grant", bus.busGrant, e.grant);
        chk("done_cmd", bus.commandOut, e.cmd);
        chk("done_srccache", bus.sourceIsCache, e.src_cache);
        chk("done_srcidx", bus.sourceIndex, e.src_idx);
        chk("ramread_cycles", rr_cyc, e.rr_cyc);
        chk("ramwrite_cycles", rw_cyc, e.rw_cyc);
        bus.busRequest    &= ~drop_mask;
        bus.snoopSupply    = '0;
        bus.snoopRamWrite  = '0;
        tick();
        chk("post_done_pulse", bus.busDone, 0);
        chk("post_grant", bus.busGrant, 0);
        chk("post_cmd", bus.commandOut, 0);
        chk("post_srccache", bus.sourceIsCache, 0);
    endtask

    initial begin
        int n;
        reset             = 1'b1;
        bus.busRequest    = '0;
        bus.busCommandIn  = '0;
        bus.snoopSupply   = '0;
        bus.snoopRamWrite = '0;
        bus.ramAck        = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b0;

        // Read miss from cache1 served by RAM, ack after 3 strobe cycles
        bus.busCommandIn = 8'h04;
        bus.busRequest   = 4'b0010;
        push_exp(4'b0010, 2'd1, 1'b0, 2'd0, 3, 0);
        run_txn(3, 1'b0, 4'b0010);

        // Dirty hit: cache2 supplies and writes back; request withdrawn mid-transaction
        bus.busCommandIn  = 8'h01;
        bus.busRequest    = 4'b0001;
        bus.snoopSupply   = 4'b0100;
        bus.snoopRamWrite = 4'b0100;
        push_exp(4'b0001, 2'd1, 1'b1, 2'd2, 0, 2);
        run_txn(2, 1'b1, 4'b0001);

        // Invalidate from cache3: broadcast then straight to done
        bus.busCommandIn = 8'hC0;
        bus.busRequest   = 4'b1000;
        push_exp(4'b1000, 2'd3, 1'b0, 2'd0, 0, 0);
        run_txn(0, 1'b0, 4'b1000);

        // Stray ramAck while idle must not start anything
        bus.ramAck = 1'b1;
        tick();
        bus.ramAck = 1'b0;
        tick();
        chk("stray_ack_grant", bus.busGrant, 0);
        chk("stray_ack_done", bus.busDone, 0);
        chk("stray_ack_ramrd", bus.ramRead, 0);

        // All four request continuously: grants rotate 0,1,2,3,0 (pointer is back at 0)
        bus.busCommandIn = 8'hFF;
        bus.busRequest   = 4'b1111;
        push_exp(4'b0001, 2'd3, 1'b0, 2'd0, 0, 0);
        push_exp(4'b0010, 2'd3, 1'b0, 2'd0, 0, 0);
        push_exp(4'b0100, 2'd3, 1'b0, 2'd0, 0, 0);
        push_exp(4'b1000, 2'd3, 1'b0, 2'd0, 0, 0);
        push_exp(4'b0001, 2'd3, 1'b0, 2'd0, 0, 0);
        run_txn(0, 1'b0, 4'b0000);
        run_txn(0, 1'b0, 4'b0000);
        run_txn(0, 1'b0, 4'b0000);
        run_txn(0, 1'b0, 4'b0000);
        run_txn(0, 1'b0, 4'b1111);

        // Pointer at 1 with requesters 0 and 2: cache2 first, then wrap to cache0
        bus.busRequest = 4'b0101;
        push_exp(4'b0100, 2'd3, 1'b0, 2'd0, 0, 0);
        push_exp(4'b0001, 2'd3, 1'b0, 2'd0, 0, 0);
        run_txn(0, 1'b0, 4'b0100);
        run_txn(0, 1'b0, 4'b0001);

        // Granted cache's own supply is masked, so RAM serves the read
        bus.busCommandIn = 8'h01;
        bus.busRequest   = 4'b0001;
        bus.snoopSupply  = 4'b0001;
        push_exp(4'b0001, 2'd1, 1'b0, 2'd0, 2, 0);
        run_txn(2, 1'b0, 4'b0001);
        chk("perr_before_multi", bus.protocolError, 0);

        // Two suppliers: lowest index wins, protocolError latches
        bus.busRequest  = 4'b0001;
        bus.snoopSupply = 4'b1010;
        push_exp(4'b0001, 2'd1, 1'b1, 2'd1, 0, 0);
        run_txn(0, 1'b0, 4'b0001);
        chk("perr_after_multi", bus.protocolError, 1);

        // Reset in the middle of a RAM read from cache1
        bus.busCommandIn = 8'h04;
        bus.busRequest   = 4'b0010;
        n = 0;
        while (bus.busGrant === '0 && n < 12) begin
            tick();
            n++;
        end
        chk("midrst_grant", bus.busGrant, 4'b0010);
        tick();
        chk("midrst_ramrd", bus.ramRead, 1);
        chk("perr_sticky", bus.protocolError, 1);
        reset          = 1'b1;
        bus.busRequest = '0;
        tick();
        chk_all_zero("midrst");
        reset = 1'b0;

        // Pointer restarted at 0: cache2 alone is granted
        bus.busCommandIn = 8'h10;
        bus.busRequest   = 4'b0100;
        last_grant_cycle = -1000;
        push_exp(4'b0100, 2'd1, 1'b0, 2'd0, 1, 0);
        run_txn(1, 1'b0, 4'b0100);
        chk("final_perr", bus.protocolError, 0);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
